// File: rtl/sram_to_sram_ctrl_if.sv
// Host and write-stage facing signal bundle for the SRAM-to-SRAM transfer sequencer.
// The master side is the host plus write stage; the slave side is the sequencer.
interface sram_to_sram_ctrl_if #(
  parameter int ADDR_BITS = 10
);
  localparam int LEN_BITS = ADDR_BITS + 1;

  logic                 start;
  logic [LEN_BITS-1:0]  len;
  logic [ADDR_BITS-1:0] rd_base;
  logic                 busy;
  logic                 done;
  logic                 wr_clear;
  logic                 mem1_ren;
  logic [ADDR_BITS-1:0] mem1_raddr;
  logic                 m_valid;
  logic                 wr_done;

  modport master (
    output start, len, rd_base, wr_done,
    input  busy, done, wr_clear, mem1_ren, mem1_raddr, m_valid
  );

  modport slave (
    input  start, len, rd_base, wr_done,
    output busy, done, wr_clear, mem1_ren, mem1_raddr, m_valid
  );
endinterface

// File: rtl/sram_to_sram_ctrl.sv
// Transfer sequencer: clears the write stage, streams LEN mem1 reads, regenerates the
// read-data valid strobe at mem1 latency and reports completion after the write stage does.
module sram_to_sram_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  sram_to_sram_ctrl_if.slave    bus
);
  localparam int LEN_BITS = ADDR_BITS + 1;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [LEN_BITS-1:0]  len_t;

  localparam len_t MAX_LEN = len_t'(1'b1) << ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    READ    = 3'd2,
    DRAIN   = 3'd3,
    WAIT_WR = 3'd4
  } state_t;

  state_t                state_r, state_s;
  len_t                  len_r, len_s;
  addr_t                 base_r, base_s;
  len_t                  rd_cnt_r, rd_cnt_s;
  logic                  flag_r, flag_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  clear_r, clear_s;
  logic                  ren_r, ren_s;
  addr_t                 raddr_r, raddr_s;
  logic [RD_LATENCY-1:0] pipe_r;

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.wr_clear   = clear_r;
  assign bus.mem1_ren   = ren_r;
  assign bus.mem1_raddr = raddr_r;
  assign bus.m_valid    = pipe_r[RD_LATENCY-1];

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_s  = state_r;
    len_s    = len_r;
    base_s   = base_r;
    rd_cnt_s = rd_cnt_r;
    flag_s   = flag_r;
    done_s   = 1'b0;
    ren_s    = 1'b0;
    raddr_s  = raddr_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != len_t'(0)) begin
            state_s  = CLEAR;
            len_s    = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
            base_s   = bus.rd_base;
            rd_cnt_s = len_t'(0);
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        state_s  = READ;
        ren_s    = 1'b1;
        raddr_s  = base_r;
        rd_cnt_s = len_t'(1);
      end
      READ: begin
        if (rd_cnt_r == len_r) begin
          state_s = DRAIN;
        end else begin
          ren_s    = 1'b1;
          raddr_s  = base_r + addr_t'(rd_cnt_r);
          rd_cnt_s = rd_cnt_r + len_t'(1);
        end
      end
      DRAIN: begin
        flag_s = flag_r | bus.wr_done;
        // The last read is already in the pipe on entry, so empty means all strobes left.
        if (pipe_r == '0) begin
          state_s = WAIT_WR;
        end else begin
          state_s = DRAIN;
        end
      end
      WAIT_WR: begin
        if (flag_r || bus.wr_done) begin
          state_s = IDLE;
          done_s  = 1'b1;
          flag_s  = 1'b0;
        end else begin
          flag_s = flag_r;
        end
      end
      default: begin
        state_s = IDLE;
        flag_s  = 1'b0;
      end
    endcase
    busy_s  = (state_s != IDLE);
    clear_s = (state_s == CLEAR);
  end

  // FSM state, latched transfer parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      len_r    <= '0;
      base_r   <= '0;
      rd_cnt_r <= '0;
      flag_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      clear_r  <= 1'b0;
      ren_r    <= 1'b0;
      raddr_r  <= '0;
    end else if (cke) begin
      state_r  <= state_s;
      len_r    <= len_s;
      base_r   <= base_s;
      rd_cnt_r <= rd_cnt_s;
      flag_r   <= flag_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      clear_r  <= clear_s;
      ren_r    <= ren_s;
      raddr_r  <= raddr_s;
    end
  end

  // Read-enable delay line modelling mem1 read latency; its tail is m_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_r <= '0;
    end else if (cke) begin
      pipe_r[0] <= ren_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end
endmodule

// File: tb/tb_sram_to_sram_ctrl.sv
// Self-checking bench: address scoreboard plus per-scenario strobe/timing checks,
// with a small write-stage model that pulses wr_done two cycles after the last m_valid.
module tb_sram_to_sram_ctrl;
  localparam int AB  = 10;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic cke;

  always #5 clk = ~clk;

  sram_to_sram_ctrl_if #(.ADDR_BITS(AB)) bus ();

  sram_to_sram_ctrl #(.ADDR_BITS(AB), .RD_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [AB-1:0] addr_q[$];
  int n_ren, n_valid, n_clear, n_done, n_busy, runs;
  int idx, first_ren, first_valid, last_valid, done_idx;
  logic mv_prev = 1'b0;
  bit rand_cke = 1'b0;

  task automatic clr_stats();
    n_ren = 0; n_valid = 0; n_clear = 0; n_done = 0; n_busy = 0; runs = 0;
    idx = 0; first_ren = -1; first_valid = -1; last_valid = -1; done_idx = -1;
  endtask

  // One clock: account for the current cycle's outputs if it is enabled, then advance.
  task automatic cyc();
    logic en;
    logic wd_n;
    logic [AB+5:0] snap;
    logic [AB-1:0] exp_a;
    en   = cke;
    wd_n = bus.wr_done;
    snap = {bus.busy, bus.done, bus.wr_clear, bus.mem1_ren, bus.m_valid, bus.wr_done, bus.mem1_raddr};
    if (en) begin
      if (bus.mem1_ren) begin
        if (first_ren < 0) first_ren = idx;
        n_ren++;
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_read addr=%h expected no read", bus.mem1_raddr);
        end else begin
          exp_a = addr_q.pop_front();
          if (bus.mem1_raddr !== exp_a) begin
            errors++;
            $display("FAIL raddr got=%h exp=%h", bus.mem1_raddr, exp_a);
          end
        end
      end
      if (bus.m_valid) begin
        if (first_valid < 0) first_valid = idx;
        if (!mv_prev) runs++;
        last_valid = idx;
        n_valid++;
      end
      if (bus.wr_clear) n_clear++;
      if (bus.busy) n_busy++;
      if (bus.done) begin
        n_done++;
        done_idx = idx;
      end
      wd_n    = mv_prev & ~bus.m_valid;
      mv_prev = bus.m_valid;
      idx++;
    end
    @(posedge clk);
    #1;
    if (!en && reset_n) begin
      checks++;
      if ({bus.busy, bus.done, bus.wr_clear, bus.mem1_ren, bus.m_valid, bus.wr_done, bus.mem1_raddr} !== snap) begin
        errors++;
        $display("FAIL cke_hold got=%h exp=%h", {bus.busy, bus.done, bus.wr_clear, bus.mem1_ren,
                 bus.m_valid, bus.wr_done, bus.mem1_raddr}, snap);
      end
    end
    bus.wr_done = wd_n;
    if (rand_cke) cke = 1'($urandom_range(0, 1));
  endtask

  task automatic push_addrs(input logic [AB-1:0] base, input int n);
    logic [AB-1:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(a);
      a = a + 10'd1;
    end
  endtask

  task automatic start_xfer(input logic [AB:0] l, input logic [AB-1:0] b);
    bus.start   = 1'b1;
    bus.len     = l;
    bus.rd_base = b;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      cyc();
      k++;
    end
    if (n_done < target) begin
      checks++;
      errors++;
      $display("FAIL timeout done_count=%0d exp=%0d", n_done, target);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cke = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.rd_base = '0; bus.wr_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.wr_clear, bus.mem1_ren, bus.m_valid} !== 5'b0 || bus.mem1_raddr !== 10'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%b raddr=%h exp=0", {bus.busy, bus.done, bus.wr_clear,
               bus.mem1_ren, bus.m_valid}, bus.mem1_raddr);
    end
    reset_n = 1'b1;
    clr_stats();
    repeat (3) cyc();
    checks++;
    if (n_busy != 0 || n_done != 0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%0d done=%0d exp=0", n_busy, n_done);
    end
  endtask

  task automatic test_basic();
    clr_stats();
    push_addrs(10'h010, 4);
    start_xfer(11'd4, 10'h010);
    wait_done(1, 200);
    checks++;
    if (n_ren != 4 || n_valid != 4 || runs != 1) begin
      errors++;
      $display("FAIL basic_counts ren=%0d valid=%0d runs=%0d exp=4/4/1", n_ren, n_valid, runs);
    end
    checks++;
    if (n_clear != 1) begin
      errors++;
      $display("FAIL basic_clear got=%0d exp=1", n_clear);
    end
    checks++;
    if (first_valid != first_ren + LAT) begin
      errors++;
      $display("FAIL basic_valid_lat got=%0d exp=%0d", first_valid, first_ren + LAT);
    end
    checks++;
    if (done_idx != last_valid + 3) begin
      errors++;
      $display("FAIL basic_done_time got=%0d exp=%0d", done_idx, last_valid + 3);
    end
    checks++;
    if (bus.busy !== 1'b0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL basic_end busy=%b left=%0d exp=0/0", bus.busy, addr_q.size());
    end
  endtask

  task automatic test_wrap();
    clr_stats();
    push_addrs(10'h3FE, 4);
    start_xfer(11'd4, 10'h3FE);
    wait_done(1, 200);
    checks++;
    if (n_ren != 4 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap ren=%0d left=%0d exp=4/0", n_ren, addr_q.size());
    end
  endtask

  task automatic test_len_zero();
    clr_stats();
    start_xfer(11'd0, 10'h123);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_pulse done=%b busy=%b exp=1/0", bus.done, bus.busy);
    end
    repeat (6) cyc();
    checks++;
    if (n_done != 1 || n_ren != 0 || n_clear != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL len0_counts done=%0d ren=%0d clr=%0d busy=%0d exp=1/0/0/0", n_done, n_ren, n_clear, n_busy);
    end
  endtask

  task automatic test_max_len();
    clr_stats();
    push_addrs(10'h005, 1024);
    start_xfer(11'h7FF, 10'h005);
    wait_done(1, 3000);
    checks++;
    if (n_ren != 1024 || n_valid != 1024 || runs != 1 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL max_len ren=%0d valid=%0d runs=%0d left=%0d exp=1024/1024/1/0", n_ren, n_valid, runs, addr_q.size());
    end
  endtask

  task automatic test_ignore_start();
    int k;
    clr_stats();
    push_addrs(10'h040, 6);
    start_xfer(11'd6, 10'h040);
    k = 0;
    while (n_ren < 2 && k < 50) begin
      cyc();
      k++;
    end
    start_xfer(11'd3, 10'h200);
    wait_done(1, 200);
    checks++;
    if (n_ren != 6 || n_clear != 1 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_start ren=%0d clr=%0d left=%0d exp=6/1/0", n_ren, n_clear, addr_q.size());
    end
    repeat (4) cyc();
    checks++;
    if (n_done != 1 || n_ren != 6) begin
      errors++;
      $display("FAIL ignore_no_queue done=%0d ren=%0d exp=1/6", n_done, n_ren);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    clr_stats();
    push_addrs(10'h100, 3);
    push_addrs(10'h180, 2);
    start_xfer(11'd3, 10'h100);
    k = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      cyc();
      k++;
    end
    start_xfer(11'd2, 10'h180);
    wait_done(2, 200);
    checks++;
    if (n_ren != 5 || n_clear != 2 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back ren=%0d clr=%0d left=%0d exp=5/2/0", n_ren, n_clear, addr_q.size());
    end
  endtask

  task automatic test_cke_random();
    clr_stats();
    cke = 1'b1;
    push_addrs(10'h3FD, 5);
    start_xfer(11'd5, 10'h3FD);
    rand_cke = 1'b1;
    wait_done(1, 2000);
    rand_cke = 1'b0;
    cke = 1'b1;
    checks++;
    if (n_ren != 5 || n_valid != 5 || runs != 1 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL cke_counts ren=%0d valid=%0d runs=%0d left=%0d exp=5/5/1/0", n_ren, n_valid, runs, addr_q.size());
    end
    checks++;
    if (first_valid != first_ren + LAT || done_idx != last_valid + 3) begin
      errors++;
      $display("FAIL cke_timing valid=%0d done=%0d exp=%0d/%0d", first_valid, done_idx, first_ren + LAT, last_valid + 3);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clr_stats();
    push_addrs(10'h050, 8);
    start_xfer(11'd8, 10'h050);
    k = 0;
    while (n_ren < 3 && k < 50) begin
      cyc();
      k++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.wr_clear, bus.mem1_ren, bus.m_valid} !== 5'b0) begin
      errors++;
      $display("FAIL async_abort got=%b exp=0", {bus.busy, bus.done, bus.wr_clear, bus.mem1_ren, bus.m_valid});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    addr_q.delete();
    mv_prev = 1'b0;
    bus.wr_done = 1'b0;
    clr_stats();
    repeat (8) cyc();
    checks++;
    if (n_done != 0 || n_ren != 0 || n_valid != 0) begin
      errors++;
      $display("FAIL abort_quiet done=%0d ren=%0d valid=%0d exp=0", n_done, n_ren, n_valid);
    end
    clr_stats();
    push_addrs(10'h060, 3);
    start_xfer(11'd3, 10'h060);
    wait_done(1, 200);
    checks++;
    if (n_ren != 3 || n_valid != 3 || n_clear != 1 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset ren=%0d valid=%0d clr=%0d left=%0d exp=3/3/1/0", n_ren, n_valid, n_clear, addr_q.size());
    end
  endtask

  initial begin
    clr_stats();
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_max_len();
    test_ignore_start();
    test_back_to_back();
    test_cke_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
